// File: rtl/fighter_anim_fsm.sv
// Fighter animation state machine: frame-paced walk/attack/hit/block sequencing
// and saturating horizontal sprite position.
module fighter_anim_fsm #(
    parameter logic [9:0]  START_X      = 10'd100,
    parameter logic        FACING_RIGHT = 1'b1,
    parameter logic [9:0]  MIN_X        = 10'd0,
    parameter logic [9:0]  MAX_X        = 10'd527,
    parameter int unsigned WALK_FWD     = 32'd3,
    parameter int unsigned WALK_BACK    = 32'd2,
    parameter int unsigned HIT_PUSH     = 32'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic       btn_dirattack,
    input  logic       btn_block,
    input  logic       got_hit,
    output logic [3:0] currentstate,
    output logic [9:0] posx,
    output logic       hit_active,
    output logic       blocking,
    output logic       block_success
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WALK     = 4'd1,
        WALKBACK = 4'd2,
        ATKSTART = 4'd3,
        ATKEND   = 4'd4,
        ATKPULL  = 4'd5,
        DIRSTART = 4'd6,
        DIREND   = 4'd7,
        DIRPULL  = 4'd8,
        GOTHIT   = 4'd9,
        BLOCK    = 4'd10
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [3:0]         cnt_r, cnt_nxt_s;
    logic [9:0]         posx_r, posx_nxt_s;
    logic               pending_hit_r;
    logic               hit_active_r, blocking_r, block_success_r;
    logic               success_nxt_s, hit_now_s, fwd_s, back_s, step_up_s;
    logic signed [10:0] step_mag_s, pos_sum_s;

    // Counter load value is duration minus one so a state entered at tick k leaves at tick k+N.
    function automatic logic [3:0] load_of(input state_t s);
        case (s)
            ATKSTART: load_of = 4'd4;
            ATKEND:   load_of = 4'd1;
            ATKPULL:  load_of = 4'd3;
            DIRSTART: load_of = 4'd3;
            DIREND:   load_of = 4'd2;
            DIRPULL:  load_of = 4'd4;
            GOTHIT:   load_of = 4'd7;
            default:  load_of = 4'd0;
        endcase
    endfunction

    function automatic state_t chain_next(input state_t s);
        case (s)
            ATKSTART: chain_next = ATKEND;
            ATKEND:   chain_next = ATKPULL;
            DIRSTART: chain_next = DIREND;
            DIREND:   chain_next = DIRPULL;
            default:  chain_next = IDLE;
        endcase
    endfunction

    assign hit_now_s = pending_hit_r | got_hit;
    assign fwd_s     = FACING_RIGHT ? btn_right : btn_left;
    assign back_s    = FACING_RIGHT ? btn_left : btn_right;

    // Next-state, frame counter and block-success decision, evaluated on frame ticks only
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        success_nxt_s = 1'b0;
        if (frame_tick) begin
            case (state_r)
                IDLE, WALK, WALKBACK: begin
                    if (hit_now_s)                state_nxt_s = GOTHIT;
                    else if (btn_attack)          state_nxt_s = ATKSTART;
                    else if (btn_dirattack)       state_nxt_s = DIRSTART;
                    else if (btn_block)           state_nxt_s = BLOCK;
                    else if (fwd_s && !back_s)    state_nxt_s = WALK;
                    else if (back_s && !fwd_s)    state_nxt_s = WALKBACK;
                    else                          state_nxt_s = IDLE;
                    cnt_nxt_s = load_of(state_nxt_s);
                end
                BLOCK: begin
                    if (hit_now_s) begin
                        state_nxt_s   = BLOCK;
                        success_nxt_s = 1'b1;
                    end else if (!btn_block) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = BLOCK;
                    end
                    cnt_nxt_s = 4'd0;
                end
                GOTHIT: begin
                    // A fresh hit while already reeling does not restart the pushback.
                    if (cnt_r == 4'd0) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = 4'd0;
                    end else begin
                        cnt_nxt_s = cnt_r - 4'd1;
                    end
                end
                ATKSTART, ATKEND, ATKPULL, DIRSTART, DIREND, DIRPULL: begin
                    if (hit_now_s) begin
                        state_nxt_s = GOTHIT;
                        cnt_nxt_s   = load_of(GOTHIT);
                    end else if (cnt_r == 4'd0) begin
                        state_nxt_s = chain_next(state_r);
                        cnt_nxt_s   = load_of(chain_next(state_r));
                    end else begin
                        cnt_nxt_s = cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
        end
    end

    // Position step for the state held before the tick, clamped to the legal range
    always_comb begin
        step_mag_s = 11'sd0;
        step_up_s  = 1'b1;
        case (state_r)
            WALK: begin
                step_mag_s = 11'(WALK_FWD);
                step_up_s  = FACING_RIGHT;
            end
            WALKBACK: begin
                step_mag_s = 11'(WALK_BACK);
                step_up_s  = ~FACING_RIGHT;
            end
            GOTHIT: begin
                step_mag_s = 11'(HIT_PUSH);
                step_up_s  = ~FACING_RIGHT;
            end
            default: begin
                step_mag_s = 11'sd0;
                step_up_s  = 1'b1;
            end
        endcase
        if (step_up_s) pos_sum_s = $signed({1'b0, posx_r}) + step_mag_s;
        else           pos_sum_s = $signed({1'b0, posx_r}) - step_mag_s;
        if (!frame_tick)                               posx_nxt_s = posx_r;
        else if (pos_sum_s < $signed({1'b0, MIN_X}))  posx_nxt_s = MIN_X;
        else if (pos_sum_s > $signed({1'b0, MAX_X}))  posx_nxt_s = MAX_X;
        else                                           posx_nxt_s = pos_sum_s[9:0];
    end

    // State, counter, position, pending-hit and decoded output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            cnt_r           <= 4'd0;
            posx_r          <= START_X;
            pending_hit_r   <= 1'b0;
            hit_active_r    <= 1'b0;
            blocking_r      <= 1'b0;
            block_success_r <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            cnt_r           <= cnt_nxt_s;
            posx_r          <= posx_nxt_s;
            pending_hit_r   <= frame_tick ? 1'b0 : (pending_hit_r | got_hit);
            hit_active_r    <= (state_nxt_s == ATKEND) || (state_nxt_s == DIREND);
            blocking_r      <= (state_nxt_s == BLOCK);
            block_success_r <= success_nxt_s;
        end
    end

    assign currentstate  = state_r;
    assign posx          = posx_r;
    assign hit_active    = hit_active_r;
    assign blocking      = blocking_r;
    assign block_success = block_success_r;

endmodule

// File: tb/tb_fighter_anim_fsm.sv
// Bench for fighter_anim_fsm: per-cycle vector table with an expected-output
// queue, plus a long walk-back run into the left screen boundary.
module tb_fighter_anim_fsm;

    logic       clk = 1'b0;
    logic       rst, frame_tick, btn_left, btn_right, btn_attack, btn_dirattack, btn_block, got_hit;
    logic [3:0] currentstate;
    logic [9:0] posx;
    logic       hit_active, blocking, block_success;

    fighter_anim_fsm #(.START_X(10'd520)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
        .btn_dirattack(btn_dirattack), .btn_block(btn_block), .got_hit(got_hit),
        .currentstate(currentstate), .posx(posx), .hit_active(hit_active),
        .blocking(blocking), .block_success(block_success)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [9:0] px;
        logic       ha;
        logic       bl;
        logic       bs;
    } out_t;

    // btn = {left, right, attack, dirattack, block}
    typedef struct {
        string      name;
        logic       rst;
        logic       tick;
        logic [4:0] btn;
        logic       hit;
        int         n;
        out_t       exp;
    } vec_t;

    vec_t tbl[$];
    out_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic row(input string name, input logic r, input logic t, input logic [4:0] b,
                       input logic h, input int n, input logic [3:0] st, input logic [9:0] px,
                       input logic ha, input logic bl, input logic bs);
        vec_t v;
        v.name = name; v.rst = r; v.tick = t; v.btn = b; v.hit = h; v.n = n;
        v.exp = '{st: st, px: px, ha: ha, bl: bl, bs: bs};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic t, input logic [4:0] b, input logic h);
        rst = r; frame_tick = t; got_hit = h;
        {btn_left, btn_right, btn_attack, btn_dirattack, btn_block} = b;
    endtask

    task automatic apply(input vec_t v);
        out_t got, want;
        drive(v.rst, v.tick, v.btn, v.hit);
        exp_q.push_back(v.exp);
        @(posedge clk); #1;
        got  = {currentstate, posx, hit_active, blocking, block_success};
        want = exp_q.pop_front();
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got st=%0d px=%0d ha=%b bl=%b bs=%b, expected st=%0d px=%0d ha=%b bl=%b bs=%b",
                      v.name, got.st, got.px, got.ha, got.bl, got.bs,
                      want.st, want.px, want.ha, want.bl, want.bs);
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'b00000, 1'b0);

        row("reset",          1'b1, 1'b0, 5'b00000, 1'b0, 2, 4'd0, 10'd520, 1'b0, 1'b0, 1'b0);
        // single attack press from IDLE
        row("atk_start",      1'b0, 1'b1, 5'b00100, 1'b0, 1, 4'd3, 10'd520, 1'b0, 1'b0, 1'b0);
        row("atk_no_tick",    1'b0, 1'b0, 5'b00100, 1'b0, 2, 4'd3, 10'd520, 1'b0, 1'b0, 1'b0);
        row("atk_start_hold", 1'b0, 1'b1, 5'b00000, 1'b0, 4, 4'd3, 10'd520, 1'b0, 1'b0, 1'b0);
        row("atk_end",        1'b0, 1'b1, 5'b00000, 1'b0, 2, 4'd4, 10'd520, 1'b1, 1'b0, 1'b0);
        row("atk_pull",       1'b0, 1'b1, 5'b00000, 1'b0, 4, 4'd5, 10'd520, 1'b0, 1'b0, 1'b0);
        row("atk_done",       1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd0, 10'd520, 1'b0, 1'b0, 1'b0);
        // both directions held
        row("both_dirs",      1'b0, 1'b1, 5'b11000, 1'b0, 3, 4'd0, 10'd520, 1'b0, 1'b0, 1'b0);
        // walk forward into MAX_X
        row("walk_enter",     1'b0, 1'b1, 5'b01000, 1'b0, 1, 4'd1, 10'd520, 1'b0, 1'b0, 1'b0);
        row("walk_523",       1'b0, 1'b1, 5'b01000, 1'b0, 1, 4'd1, 10'd523, 1'b0, 1'b0, 1'b0);
        row("walk_526",       1'b0, 1'b1, 5'b01000, 1'b0, 1, 4'd1, 10'd526, 1'b0, 1'b0, 1'b0);
        row("walk_sat",       1'b0, 1'b1, 5'b01000, 1'b0, 1, 4'd1, 10'd527, 1'b0, 1'b0, 1'b0);
        row("walk_release",   1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd0, 10'd527, 1'b0, 1'b0, 1'b0);
        row("idle_hold",      1'b0, 1'b0, 5'b01000, 1'b0, 2, 4'd0, 10'd527, 1'b0, 1'b0, 1'b0);
        // walk backward
        row("back_enter",     1'b0, 1'b1, 5'b10000, 1'b0, 1, 4'd2, 10'd527, 1'b0, 1'b0, 1'b0);
        row("back_525",       1'b0, 1'b1, 5'b10000, 1'b0, 1, 4'd2, 10'd525, 1'b0, 1'b0, 1'b0);
        row("back_release",   1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd0, 10'd523, 1'b0, 1'b0, 1'b0);
        // hit between ticks during DIRSTART, then pushback with a second hit ignored
        row("dir_start",      1'b0, 1'b1, 5'b00010, 1'b0, 1, 4'd6, 10'd523, 1'b0, 1'b0, 1'b0);
        row("dir_hit_wait",   1'b0, 1'b0, 5'b00000, 1'b1, 1, 4'd6, 10'd523, 1'b0, 1'b0, 1'b0);
        row("dir_hit_pend",   1'b0, 1'b0, 5'b00000, 1'b0, 1, 4'd6, 10'd523, 1'b0, 1'b0, 1'b0);
        row("gothit_enter",   1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd9, 10'd523, 1'b0, 1'b0, 1'b0);
        row("gothit_519",     1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd9, 10'd519, 1'b0, 1'b0, 1'b0);
        row("gothit_515",     1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd9, 10'd515, 1'b0, 1'b0, 1'b0);
        row("gothit_rehit",   1'b0, 1'b0, 5'b00000, 1'b1, 1, 4'd9, 10'd515, 1'b0, 1'b0, 1'b0);
        row("gothit_511",     1'b0, 1'b1, 5'b00100, 1'b0, 1, 4'd9, 10'd511, 1'b0, 1'b0, 1'b0);
        row("gothit_507",     1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd9, 10'd507, 1'b0, 1'b0, 1'b0);
        row("gothit_503",     1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd9, 10'd503, 1'b0, 1'b0, 1'b0);
        row("gothit_499",     1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd9, 10'd499, 1'b0, 1'b0, 1'b0);
        row("gothit_495",     1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd9, 10'd495, 1'b0, 1'b0, 1'b0);
        row("gothit_exit",    1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd0, 10'd491, 1'b0, 1'b0, 1'b0);
        row("hit_consumed",   1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd0, 10'd491, 1'b0, 1'b0, 1'b0);
        // block absorbs a hit with a single-cycle success pulse
        row("block_enter",    1'b0, 1'b1, 5'b00001, 1'b0, 2, 4'd10, 10'd491, 1'b0, 1'b1, 1'b0);
        row("block_hit_wait", 1'b0, 1'b0, 5'b00001, 1'b1, 1, 4'd10, 10'd491, 1'b0, 1'b1, 1'b0);
        row("block_success",  1'b0, 1'b1, 5'b00001, 1'b0, 1, 4'd10, 10'd491, 1'b0, 1'b1, 1'b1);
        row("block_pulse_end",1'b0, 1'b0, 5'b00001, 1'b0, 1, 4'd10, 10'd491, 1'b0, 1'b1, 1'b0);
        row("block_hold",     1'b0, 1'b1, 5'b00001, 1'b0, 1, 4'd10, 10'd491, 1'b0, 1'b1, 1'b0);
        row("block_release",  1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd0, 10'd491, 1'b0, 1'b0, 1'b0);
        // reset during ATKEND together with a tick and a hit
        row("rst_atk_start",  1'b0, 1'b1, 5'b00100, 1'b0, 1, 4'd3, 10'd491, 1'b0, 1'b0, 1'b0);
        row("rst_atk_hold",   1'b0, 1'b1, 5'b00000, 1'b0, 4, 4'd3, 10'd491, 1'b0, 1'b0, 1'b0);
        row("rst_atk_end",    1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd4, 10'd491, 1'b1, 1'b0, 1'b0);
        row("rst_mid_atk",    1'b1, 1'b1, 5'b00000, 1'b1, 1, 4'd0, 10'd520, 1'b0, 1'b0, 1'b0);
        row("rst_no_pending", 1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd0, 10'd520, 1'b0, 1'b0, 1'b0);
        // hit interrupts an attack
        row("atk2_start",     1'b0, 1'b1, 5'b00100, 1'b0, 1, 4'd3, 10'd520, 1'b0, 1'b0, 1'b0);
        row("atk2_hit_wait",  1'b0, 1'b0, 5'b00000, 1'b1, 1, 4'd3, 10'd520, 1'b0, 1'b0, 1'b0);
        row("atk2_gothit",    1'b0, 1'b1, 5'b00100, 1'b0, 1, 4'd9, 10'd520, 1'b0, 1'b0, 1'b0);
        row("atk2_push",      1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd9, 10'd516, 1'b0, 1'b0, 1'b0);
        row("atk2_rst",       1'b1, 1'b0, 5'b00000, 1'b0, 1, 4'd0, 10'd520, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) apply(tbl[i]);
        end

        // long walk back: enters WALKBACK then 299 steps of 2 from 520, clamped at MIN_X
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, 5'b10000, 1'b0);
            @(posedge clk); #1;
        end
        tbl.delete();
        row("min_sat",        1'b0, 1'b0, 5'b00000, 1'b0, 1, 4'd2, 10'd0, 1'b0, 1'b0, 1'b0);
        row("min_sat_exit",   1'b0, 1'b1, 5'b00000, 1'b0, 1, 4'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
